// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: host command codes, the
// loader FSM state encoding and bytes-per-word for each target memory.
package prog_loader_pkg;

  localparam logic [7:0] CMD_LOAD_I = 8'h01;  // load instruction memory
  localparam logic [7:0] CMD_LOAD_D = 8'h02;  // load data memory
  localparam logic [7:0] CMD_START  = 8'h03;  // enable CPU
  localparam logic [7:0] CMD_STOP   = 8'h04;  // disable CPU (only honoured in RUN)

  localparam int IMEM_BPW = 4;
  localparam int DMEM_BPW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// byte_assembler: shifts accepted bytes into a 64-bit word, LSB first.
//   clk, arst_n : clock, async active-low reset
//   clr         : restart assembly at byte 0
//   shift       : din is accepted this cycle
//   din         : incoming byte
//   wide        : 1 = 8-byte words, 0 = 4-byte words
//   word        : word including this cycle's byte, right-aligned
//   last        : this cycle's byte completes the word
module byte_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  input  logic        wide,
  output logic [63:0] word,
  output logic        last
);

  logic [63:0] sh_q, sh_nxt;
  logic [2:0]  cnt;

  // Bytes enter at the top and move down, so after 8 bytes the first one
  // sits in [7:0]; a 4-byte word ends up in [63:32] and is shifted down.
  always_comb begin
    sh_nxt = sh_q;
    if (shift) sh_nxt = {din, sh_q[63:8]};
  end

  assign word = wide ? sh_nxt : {32'b0, sh_nxt[63:32]};
  assign last = shift && (cnt == (wide ? 3'(DMEM_BPW - 1) : 3'(IMEM_BPW - 1)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sh_q <= '0;
      cnt  <= '0;
    end else if (clr) begin
      sh_q <= '0;
      cnt  <= '0;
    end else if (shift) begin
      sh_q <= sh_nxt;
      cnt  <= last ? 3'd0 : cnt + 3'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: parses a host byte stream into instruction/data memory
// write frames and start/stop commands for the CPU.
//   clk, arst_n                 : clock, async active-low reset
//   in_valid, in_data, in_ready : host byte stream handshake
//   *_ext                       : instruction memory write port (32-bit)
//   *_ext_2                     : data memory write port (64-bit)
//   cpu_enable                  : CPU run enable
//   busy                        : frame in progress
//   err                         : sticky protocol error, cleared only by reset
//   words_loaded                : words written by current/last load frame
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] IDEPTH = 32'(IMEM_WORDS);
  localparam logic [31:0] DDEPTH = 32'(DMEM_WORDS);

  state_t      state;
  logic        is_d;      // current frame targets data memory
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  xsum;      // running XOR of the frame so far
  logic        acc;
  logic [15:0] n_rx;
  logic [63:0] asm_word;
  logic        asm_last;

  assign in_ready  = (state != ST_WRITE);
  assign busy      = !(state inside {ST_IDLE, ST_RUN, ST_ERR});
  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;
  assign acc       = in_valid && in_ready;
  assign n_rx      = {in_data, len_lo};

  byte_assembler u_asm (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    ((state == ST_IDLE) && acc),
    .shift  ((state == ST_DATA) && acc),
    .din    (in_data),
    .wide   (is_d),
    .word   (asm_word),
    .last   (asm_last)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= ST_IDLE;
      is_d         <= 1'b0;
      len_lo       <= '0;
      len          <= '0;
      xsum         <= '0;
      addr_ext     <= '0;
      wen_ext      <= 1'b0;
      wdata_ext    <= '0;
      addr_ext_2   <= '0;
      wen_ext_2    <= 1'b0;
      wdata_ext_2  <= '0;
      cpu_enable   <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      // Strobes are raised on entry to WRITE and drop after its one cycle.
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      case (state)
        ST_IDLE: if (acc) begin
          if (in_data == CMD_LOAD_I || in_data == CMD_LOAD_D) begin
            is_d         <= (in_data == CMD_LOAD_D);
            xsum         <= in_data;
            words_loaded <= '0;
            state        <= ST_LEN0;
          end else if (in_data == CMD_START) begin
            cpu_enable <= 1'b1;
            state      <= ST_RUN;
          end else begin
            err   <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_LEN0: if (acc) begin
          len_lo <= in_data;
          xsum   <= xsum ^ in_data;
          state  <= ST_LEN1;
        end
        ST_LEN1: if (acc) begin
          xsum <= xsum ^ in_data;
          len  <= n_rx;
          if (32'(n_rx) > (is_d ? DDEPTH : IDEPTH)) begin
            err   <= 1'b1;
            state <= ST_ERR;
          end else if (n_rx == 16'd0) begin
            state <= ST_CHK;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_DATA: if (acc) begin
          xsum <= xsum ^ in_data;
          if (asm_last) begin
            state <= ST_WRITE;
            if (is_d) begin
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= {45'b0, words_loaded, 3'b0};
              wdata_ext_2 <= asm_word;
            end else begin
              wen_ext   <= 1'b1;
              addr_ext  <= {46'b0, words_loaded, 2'b0};
              wdata_ext <= asm_word[31:0];
            end
          end
        end
        ST_WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          state        <= (words_loaded + 16'd1 == len) ? ST_CHK : ST_DATA;
        end
        ST_CHK: if (acc) begin
          if (in_data == xsum) begin
            state <= ST_IDLE;
          end else begin
            err   <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_RUN: if (acc && in_data == CMD_STOP) begin
          cpu_enable <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_ERR;  // ERR is held until reset
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        cpu_enable, busy, err;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;
  logic [15:0] words_loaded;

  prog_loader dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .addr_ext(addr_ext), .wen_ext(wen_ext),
    .ren_ext(ren_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2),
    .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic mem; logic [63:0] addr; logic [63:0] data; } wr_t;

  typedef struct {
    logic [7:0]  b [16];
    int          nb;
    logic        e_err, e_cpu, e_busy;
    logic [15:0] e_wl;
    int          e_nw;
    logic        e_mem;
    logic [63:0] e_a [2];
    logic [63:0] e_d [2];
  } vec_t;

  localparam int NV = 11;
  vec_t tv [NV];

  int   checks = 0, errors = 0;
  wr_t  obs_q[$], exp_q[$];
  logic m_err, m_run;
  logic [15:0] m_wl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor: every strobe is recorded; strobes must be exclusive and
  // only appear while the loader is stalling the host.
  always @(negedge clk) begin
    if (wen_ext || wen_ext_2) begin
      chk("wen exclusive", {63'b0, wen_ext && wen_ext_2}, 64'd0);
      chk("in_ready during write", {63'b0, in_ready}, 64'd0);
      chk("busy during write", {63'b0, busy}, 64'd1);
      if (wen_ext_2) obs_q.push_back('{1'b1, addr_ext_2, wdata_ext_2});
      else           obs_q.push_back('{1'b0, addr_ext, {32'b0, wdata_ext}});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk_reset(input string t);
    chk({t, " in_ready"}, {63'b0, in_ready}, 64'd1);
    chk({t, " wen_ext"}, {63'b0, wen_ext}, 64'd0);
    chk({t, " wen_ext_2"}, {63'b0, wen_ext_2}, 64'd0);
    chk({t, " ren"}, {62'b0, ren_ext, ren_ext_2}, 64'd0);
    chk({t, " cpu_enable"}, {63'b0, cpu_enable}, 64'd0);
    chk({t, " err"}, {63'b0, err}, 64'd0);
    chk({t, " busy"}, {63'b0, busy}, 64'd0);
    chk({t, " words_loaded"}, {48'b0, words_loaded}, 64'd0);
    chk({t, " addr_ext"}, addr_ext, 64'd0);
    chk({t, " wdata_ext"}, {32'b0, wdata_ext}, 64'd0);
    chk({t, " addr_ext_2"}, addr_ext_2, 64'd0);
    chk({t, " wdata_ext_2"}, wdata_ext_2, 64'd0);
  endtask

  task automatic model_reset();
    m_err = 1'b0; m_run = 1'b0; m_wl = '0;
    exp_q.delete();
  endtask

  // Enters and leaves on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    arst_n = 1'b0;
    #2;
    chk_reset("reset");
    @(negedge clk);
    arst_n = 1'b1;
    obs_q.delete();
    model_reset();
  endtask

  // Enters and leaves on a falling edge; in_valid stays high on exit so
  // consecutive bytes can stream back to back.
  task automatic send_byte(input logic [7:0] b, input int gmax);
    int tries = 0;
    repeat ($urandom_range(0, gmax)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready timeout: got 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input bq_t f, input int gmax);
    foreach (f[i]) send_byte(f[i], gmax);
    in_valid = 1'b0;
  endtask

  // Frame-level reference: decodes a whole frame from the byte rules.
  task automatic model_frame(input bq_t f);
    int n, bpw, depth;
    logic [7:0] x;
    logic [63:0] w;
    if (m_err) return;
    if (m_run) begin
      if (f[0] == 8'h04) m_run = 1'b0;
      return;
    end
    if (f[0] == 8'h03) begin
      m_run = 1'b1;
    end else if (f[0] == 8'h01 || f[0] == 8'h02) begin
      m_wl = '0;
      n = int'({f[2], f[1]});
      bpw = (f[0] == 8'h02) ? 8 : 4;
      depth = (f[0] == 8'h02) ? 1024 : 512;
      if (n > depth) begin m_err = 1'b1; return; end
      for (int i = 0; i < n; i++) begin
        w = '0;
        for (int k = 0; k < bpw; k++) w = w | (64'(f[3 + i*bpw + k]) << (8*k));
        exp_q.push_back('{f[0] == 8'h02, 64'(i*bpw), w});
      end
      m_wl = 16'(n);
      x = '0;
      for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
      if (f[f.size()-1] != x) m_err = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic cmp_writes(input string t);
    int n;
    chk($sformatf("%s nwrites", t), 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s w%0d mem", t, i), {63'b0, obs_q[i].mem}, {63'b0, exp_q[i].mem});
      chk($sformatf("%s w%0d addr", t, i), obs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s w%0d data", t, i), obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_state(input string t);
    chk({t, " err"}, {63'b0, err}, {63'b0, m_err});
    chk({t, " cpu"}, {63'b0, cpu_enable}, {63'b0, m_run});
    chk({t, " busy"}, {63'b0, busy}, 64'd0);
    chk({t, " wl"}, {48'b0, words_loaded}, {48'b0, m_wl});
    cmp_writes(t);
  endtask

  task automatic set_vec(input int k, input bq_t q, input logic er, cp, bz,
                         input logic [15:0] wl, input int nw, input logic mem,
                         input logic [63:0] a0, d0, a1, d1);
    foreach (tv[k].b[i]) tv[k].b[i] = (i < q.size()) ? q[i] : 8'h00;
    tv[k].nb = q.size();
    tv[k].e_err = er; tv[k].e_cpu = cp; tv[k].e_busy = bz;
    tv[k].e_wl = wl; tv[k].e_nw = nw; tv[k].e_mem = mem;
    tv[k].e_a[0] = a0; tv[k].e_d[0] = d0;
    tv[k].e_a[1] = a1; tv[k].e_d[1] = d1;
  endtask

  bq_t q;

  initial begin
    q = {8'h01,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h29};
    set_vec(0, q, 0, 0, 0, 2, 2, 0, 0, 64'h12345678, 4, 64'hDEADBEEF);
    q = {8'h02,8'h01,8'h00,8'hEF,8'hCD,8'hAB,8'h89,8'h67,8'h45,8'h23,8'h01,8'h03};
    set_vec(1, q, 0, 0, 0, 1, 1, 1, 0, 64'h0123456789ABCDEF, 0, 0);
    q = {8'h03,8'h04};
    set_vec(2, q, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q = {8'h01,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h28,8'h03};
    set_vec(3, q, 1, 0, 0, 2, 2, 0, 0, 64'h12345678, 4, 64'hDEADBEEF);
    q = {8'h01,8'h01,8'h02};
    set_vec(4, q, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q = {8'h01,8'h00,8'h00,8'h01};
    set_vec(5, q, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q = {8'h07};
    set_vec(6, q, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q = {8'h03,8'hAA,8'h01};
    set_vec(7, q, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    q = {8'h02,8'h01,8'h04};
    set_vec(8, q, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    q = {8'h01,8'h00,8'h02};
    set_vec(9, q, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    q = {8'h02,8'h00,8'h04};
    set_vec(10, q, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Table vectors, each from reset with back-to-back bytes.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int i = 0; i < tv[v].nb; i++) send_byte(tv[v].b[i], 0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d err", v), {63'b0, err}, {63'b0, tv[v].e_err});
      chk($sformatf("v%0d cpu", v), {63'b0, cpu_enable}, {63'b0, tv[v].e_cpu});
      chk($sformatf("v%0d busy", v), {63'b0, busy}, {63'b0, tv[v].e_busy});
      chk($sformatf("v%0d wl", v), {48'b0, words_loaded}, {48'b0, tv[v].e_wl});
      for (int i = 0; i < tv[v].e_nw; i++)
        exp_q.push_back('{tv[v].e_mem, tv[v].e_a[i], tv[v].e_d[i]});
      cmp_writes($sformatf("v%0d", v));
    end

    // cpu_enable edge timing around start/stop, then confirm IDLE.
    do_reset();
    chk("run pre", {63'b0, cpu_enable}, 64'd0);
    send_byte(8'h03, 0);
    chk("run rise", {63'b0, cpu_enable}, 64'd1);
    send_byte(8'h04, 0);
    chk("run fall", {63'b0, cpu_enable}, 64'd0);
    in_valid = 1'b0;
    send_byte(8'h01, 0);
    in_valid = 1'b0;
    chk("run idle", {63'b0, busy}, 64'd1);

    // Gapped stream gives the same writes.
    do_reset();
    q = {8'h01,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h29};
    send_frame(q, 3);
    model_frame(q);
    repeat (2) @(negedge clk);
    chk_state("gaps");

    // Reset mid-payload.
    do_reset();
    q = {8'h01,8'h02,8'h00,8'h78,8'h56};
    send_frame(q, 2);
    #2 arst_n = 1'b0;
    #1 chk_reset("mid payload");
    @(negedge clk);
    arst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid payload writes", 64'(obs_q.size()), 64'd0);
    obs_q.delete();

    // Reset during WRITE: strobe drops at once and does not return.
    q = {8'h01,8'h01,8'h00,8'h78,8'h56,8'h34,8'h12};
    send_frame(q, 0);
    chk("in write wen", {63'b0, wen_ext}, 64'd1);
    #2 arst_n = 1'b0;
    #1 chk_reset("mid write");
    obs_q.delete();
    @(negedge clk);
    arst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid write writes", 64'(obs_q.size()), 64'd0);

    // Full-depth instruction load.
    do_reset();
    begin
      bq_t f;
      logic [7:0] x;
      f = {8'h01, 8'h00, 8'h02};
      for (int i = 0; i < 2048; i++) f.push_back(8'($urandom));
      x = '0;
      foreach (f[i]) x ^= f[i];
      f.push_back(x);
      send_frame(f, 0);
      model_frame(f);
    end
    repeat (2) @(negedge clk);
    chk_state("depth512");

    // Randomized frames against the reference model.
    do_reset();
    for (int op = 0; op < 40; op++) begin
      bq_t f;
      int r, n, bpw;
      logic [7:0] cmd, x;
      if (m_err) do_reset();
      f = {};
      if (m_run) begin
        f.push_back(($urandom_range(0, 2) == 0) ? 8'($urandom_range(5, 255)) : 8'h04);
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0) f.push_back(8'h03);
        else if (r == 1) f.push_back(8'($urandom_range(5, 255)));
        else begin
          cmd = $urandom_range(0, 1) ? 8'h02 : 8'h01;
          n = $urandom_range(0, 4);
          bpw = (cmd == 8'h02) ? 8 : 4;
          f.push_back(cmd);
          f.push_back(n[7:0]);
          f.push_back(8'h00);
          for (int i = 0; i < n*bpw; i++) f.push_back(8'($urandom));
          x = '0;
          foreach (f[i]) x ^= f[i];
          if (r == 2) x ^= 8'($urandom_range(1, 255));
          f.push_back(x);
        end
      end
      send_frame(f, $urandom_range(0, 3));
      model_frame(f);
      repeat (2) @(negedge clk);
      chk_state($sformatf("rand%0d", op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
